// File: rtl/q2_mem_arbiter_if.sv
// ============================================================================
// Module      : q2_mem_arbiter_if
// Description : Request/acknowledge handshake bundle for the two q2 memory
//               bus requesters (CPU core and front-panel loader).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface q2_mem_arbiter_if #(
    parameter int WIDTH  = 12,
    parameter int AWIDTH = 12
);
    logic              cpu_req;
    logic              cpu_we;
    logic [AWIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_ack;

    logic              pnl_req;
    logic              pnl_we;
    logic [AWIDTH-1:0] pnl_addr;
    logic [WIDTH-1:0]  pnl_wdata;
    logic              pnl_ack;

    // Requester side: raises requests, receives completion pulses
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output pnl_req, pnl_we, pnl_addr, pnl_wdata,
        input  cpu_ack, pnl_ack
    );

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  pnl_req, pnl_we, pnl_addr, pnl_wdata,
        output cpu_ack, pnl_ack
    );
endinterface

`default_nettype wire

// File: rtl/q2_mem_arbiter.sv
// ============================================================================
// Module      : q2_mem_arbiter
// Description : Shares the single q2 memory bus between the CPU core and the
//               front-panel loader. One access in flight; each access runs
//               SETUP -> STROBE -> ACK after the grant cycle. Round-robin or
//               fixed CPU priority on simultaneous requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q2_mem_arbiter #(
    parameter int WIDTH     = 12,
    parameter int AWIDTH    = 12,
    parameter int FIXED_PRI = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,      // asynchronous, active low
    q2_mem_arbiter_if.slave        req_if,
    output logic [WIDTH-1:0]       rdata,
    output logic [AWIDTH-1:0]      abus,
    inout  wire  [WIDTH-1:0]       dbus,
    output logic                   rdm,
    output logic                   wrm,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_PNL = 1'b1;

    state_t            state_q,   state_d;
    logic              owner_q,   owner_d;
    logic              last_q,    last_d;
    logic              we_q,      we_d;
    logic [AWIDTH-1:0] addr_q,    addr_d;
    logic [WIDTH-1:0]  wdata_q,   wdata_d;
    logic [WIDTH-1:0]  rdata_q,   rdata_d;
    logic              rdm_q,     rdm_d;
    logic              wrm_q,     wrm_d;
    logic              oe_q,      oe_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              pnl_ack_q, pnl_ack_d;
    logic              busy_q,    busy_d;

    logic              pick_pnl;
    logic              sel_we;

    // Next-state and next-output computation; every bus output is registered
    // so rdm/wrm/dbus enables come straight from flops (no glitches on wrm).
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rdm_d     = rdm_q;
        wrm_d     = wrm_q;
        oe_d      = oe_q;
        cpu_ack_d = 1'b0;
        pnl_ack_d = 1'b0;
        busy_d    = busy_q;

        // Panel wins only when the CPU is absent, or on a round-robin tie
        // where the CPU held the previous grant.
        pick_pnl = req_if.pnl_req &&
                   (!req_if.cpu_req || ((FIXED_PRI == 0) && (last_q == OWN_CPU)));
        sel_we   = pick_pnl ? req_if.pnl_we : req_if.cpu_we;

        case (state_q)
            S_IDLE: begin
                if (req_if.cpu_req || req_if.pnl_req) begin
                    owner_d = pick_pnl ? OWN_PNL : OWN_CPU;
                    last_d  = pick_pnl ? OWN_PNL : OWN_CPU;
                    we_d    = sel_we;
                    addr_d  = pick_pnl ? req_if.pnl_addr  : req_if.cpu_addr;
                    wdata_d = pick_pnl ? req_if.pnl_wdata : req_if.cpu_wdata;
                    rdm_d   = !sel_we;
                    wrm_d   = 1'b0;
                    oe_d    = sel_we;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Data has been on dbus for a full cycle before wrm rises
                rdm_d   = !we_q;
                wrm_d   = we_q;
                oe_d    = we_q;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (!we_q) begin
                    rdata_d = dbus;
                end
                rdm_d     = 1'b0;
                wrm_d     = 1'b0;
                oe_d      = 1'b0;
                cpu_ack_d = (owner_q == OWN_CPU);
                pnl_ack_d = (owner_q == OWN_PNL);
                state_d   = S_ACK;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight and leaves the
    // panel as last grantee so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_CPU;
            last_q    <= OWN_PNL;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rdm_q     <= 1'b0;
            wrm_q     <= 1'b0;
            oe_q      <= 1'b0;
            cpu_ack_q <= 1'b0;
            pnl_ack_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rdm_q     <= rdm_d;
            wrm_q     <= wrm_d;
            oe_q      <= oe_d;
            cpu_ack_q <= cpu_ack_d;
            pnl_ack_q <= pnl_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign dbus           = oe_q ? wdata_q : {WIDTH{1'bz}};
    assign abus           = addr_q;
    assign rdata          = rdata_q;
    assign rdm            = rdm_q;
    assign wrm            = wrm_q;
    assign busy           = busy_q;
    assign req_if.cpu_ack = cpu_ack_q;
    assign req_if.pnl_ack = pnl_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_q2_mem_arbiter.sv
// ============================================================================
// Module      : tb_q2_mem_arbiter
// Description : Self-checking bench for q2_mem_arbiter. Two DUTs run side by
//               side (round-robin and fixed CPU priority), each with its own
//               RAM and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q2_mem_arbiter;

    localparam int W  = 12;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        cpu_req [2];
    logic        cpu_we  [2];
    logic [11:0] cpu_addr [2];
    logic [11:0] cpu_wdata[2];
    logic        pnl_req [2];
    logic        pnl_we  [2];
    logic [11:0] pnl_addr [2];
    logic [11:0] pnl_wdata[2];
    logic        cpu_ack [2];
    logic        pnl_ack [2];
    logic        rdm     [2];
    logic        wrm     [2];
    logic        busy    [2];
    logic [11:0] abus    [2];
    logic [11:0] rdata   [2];
    logic [11:0] dbus_v  [2];

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    // Power-up RAM contents; 0x123 holds 0x5A5
    function automatic logic [11:0] init_val(input logic [11:0] a);
        return (a == 12'h123) ? 12'h5A5 : 12'(a * 12'd5 + 12'd3);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int FP = g;

        q2_mem_arbiter_if #(.WIDTH(W), .AWIDTH(AW)) ifc ();
        wire [11:0] dbus;

        assign ifc.cpu_req   = cpu_req[g];
        assign ifc.cpu_we    = cpu_we[g];
        assign ifc.cpu_addr  = cpu_addr[g];
        assign ifc.cpu_wdata = cpu_wdata[g];
        assign ifc.pnl_req   = pnl_req[g];
        assign ifc.pnl_we    = pnl_we[g];
        assign ifc.pnl_addr  = pnl_addr[g];
        assign ifc.pnl_wdata = pnl_wdata[g];
        assign cpu_ack[g]    = ifc.cpu_ack;
        assign pnl_ack[g]    = ifc.pnl_ack;
        assign dbus_v[g]     = dbus;

        q2_mem_arbiter #(.WIDTH(W), .AWIDTH(AW), .FIXED_PRI(FP)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .req_if (ifc.slave),
            .rdata  (rdata[g]),
            .abus   (abus[g]),
            .dbus   (dbus),
            .rdm    (rdm[g]),
            .wrm    (wrm[g]),
            .busy   (busy[g])
        );

        // External RAM: combinational read, write on wrm rise
        logic [11:0] ram [4096];
        assign dbus = rdm[g] ? ram[abus[g]] : 12'bz;
        initial begin
            for (int i = 0; i < 4096; i++) ram[i] = init_val(12'(i));
            forever begin
                @(posedge wrm[g]);
                ram[abus[g]] = dbus;
            end
        end

        // Reference model: m_t counts cycles since the grant (0 = no access)
        logic [11:0] mm [4096];
        int          m_t;
        logic        m_own, m_we, m_last;
        logic [11:0] m_addr, m_wdata, m_abus, m_rdata;
        initial begin
            for (int i = 0; i < 4096; i++) mm[i] = init_val(12'(i));
            m_t = 0; m_own = 1'b0; m_we = 1'b0; m_last = 1'b1;
            m_addr = '0; m_wdata = '0; m_abus = '0; m_rdata = '0;
            forever begin
                @(posedge clk or negedge rst);
                if (!rst) begin
                    m_t = 0; m_last = 1'b1; m_abus = '0; m_rdata = '0;
                end else if (m_t == 0) begin
                    if (cpu_req[g] || pnl_req[g]) begin
                        if (cpu_req[g] && pnl_req[g]) m_own = (FP != 0) ? 1'b0 : ~m_last;
                        else                          m_own = pnl_req[g];
                        m_we    = m_own ? pnl_we[g]    : cpu_we[g];
                        m_addr  = m_own ? pnl_addr[g]  : cpu_addr[g];
                        m_wdata = m_own ? pnl_wdata[g] : cpu_wdata[g];
                        m_last  = m_own;
                        m_abus  = m_addr;
                        m_t     = 1;
                    end
                end else if (m_t == 1) begin
                    if (m_we) mm[m_addr] = m_wdata;   // RAM latches on the wrm rise
                    m_t = 2;
                end else if (m_t == 2) begin
                    if (!m_we) m_rdata = mm[m_addr];
                    m_t = 3;
                end else begin
                    m_t = 0;
                end
            end
        end

        // Cycle-by-cycle comparison against the model
        always @(negedge clk) begin
            if (rst) begin
                chk("busy",    g, 32'(busy[g]),    32'(m_t != 0));
                chk("rdm",     g, 32'(rdm[g]),     32'(!m_we && (m_t == 1 || m_t == 2)));
                chk("wrm",     g, 32'(wrm[g]),     32'(m_we && m_t == 2));
                chk("cpu_ack", g, 32'(cpu_ack[g]), 32'(m_t == 3 && !m_own));
                chk("pnl_ack", g, 32'(pnl_ack[g]), 32'(m_t == 3 && m_own));
                chk("abus",    g, 32'(abus[g]),    32'(m_abus));
                chk("rdata",   g, 32'(rdata[g]),   32'(m_rdata));
                if (m_we && (m_t == 1 || m_t == 2))
                    chk("dbus", g, 32'(dbus), 32'(m_wdata));
            end
        end
    end

    task automatic rand_fields(input int g, input bit pnl);
        if (pnl) begin
            pnl_we[g]    = 1'($urandom_range(1, 0));
            pnl_addr[g]  = 12'($urandom_range(15, 0));
            pnl_wdata[g] = 12'($urandom);
        end else begin
            cpu_we[g]    = 1'($urandom_range(1, 0));
            cpu_addr[g]  = 12'($urandom_range(15, 0));
            cpu_wdata[g] = 12'($urandom);
        end
    endtask

    // Single CPU read on instance g; returns data and cycles until ack (-1 on timeout)
    task automatic cpu_read(input int g, input logic [11:0] a, output logic [11:0] rd, output int lat);
        cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_addr[g] = a;
        lat = -1; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cpu_ack[g]) begin lat = i; rd = rdata[g]; break; end
        end
        cpu_req[g] = 1'b0;
    endtask

    initial begin
        logic [11:0] rd, a_at, d_at;
        int lat, n_rdm, n_rise, n_ack, n0, c1, p1;
        logic prev, found;
        int who0 [8];
        int when0[8];

        for (int g = 0; g < 2; g++) begin
            cpu_req[g] = 0; cpu_we[g] = 0; cpu_addr[g] = 0; cpu_wdata[g] = 0;
            pnl_req[g] = 0; pnl_we[g] = 0; pnl_addr[g] = 0; pnl_wdata[g] = 0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_busy",  0, 32'(busy[0]),  0);
        chk("rst_rdm",   0, 32'(rdm[0]),   0);
        chk("rst_wrm",   0, 32'(wrm[0]),   0);
        chk("rst_abus",  0, 32'(abus[0]),  0);
        chk("rst_rdata", 0, 32'(rdata[0]), 0);

        // CPU read of 0x123
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 12'h123;
        n_rdm = 0; lat = -1; rd = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rdm[0]) n_rdm++;
            if (cpu_ack[0]) begin lat = i; rd = rdata[0]; break; end
        end
        cpu_req[0] = 0;
        chk("t1_latency", 0, 32'(lat),   3);
        chk("t1_rdm_cyc", 0, 32'(n_rdm), 2);
        chk("t1_rdata",   0, 32'(rd),    32'h5A5);

        // Panel deposit 0x010 <- 0xABC
        pnl_req[0] = 1; pnl_we[0] = 1; pnl_addr[0] = 12'h010; pnl_wdata[0] = 12'hABC;
        n_rise = 0; n_ack = 0; prev = 0; a_at = '0; d_at = '0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (wrm[0] && !prev) begin n_rise++; a_at = abus[0]; d_at = dbus_v[0]; end
            prev = wrm[0];
            if (pnl_ack[0]) begin n_ack++; pnl_req[0] = 0; end
        end
        chk("t2_wrm_rises", 0, 32'(n_rise), 1);
        chk("t2_abus",      0, 32'(a_at),   32'h010);
        chk("t2_dbus",      0, 32'(d_at),   32'hABC);
        chk("t2_acks",      0, 32'(n_ack),  1);
        cpu_read(0, 12'h010, rd, lat);
        chk("t2_readback",  0, 32'(rd),     32'hABC);
        chk("t2_rd_lat",    0, 32'(lat),    3);

        // Both requesters held: alternate (RR) vs CPU always (fixed)
        rst = 0; @(negedge clk); rst = 1; @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            cpu_req[g] = 1; cpu_we[g] = 0; cpu_addr[g] = 12'h030;
            pnl_req[g] = 1; pnl_we[g] = 0; pnl_addr[g] = 12'h031;
        end
        n0 = 0; c1 = 0; p1 = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if ((cpu_ack[0] || pnl_ack[0]) && n0 < 8) begin
                who0[n0] = pnl_ack[0] ? 1 : 0; when0[n0] = i; n0++;
            end
            if (cpu_ack[1]) c1++;
            if (pnl_ack[1]) p1++;
        end
        chk("t3_nacks", 0, 32'(n0), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n0) begin
                chk("t3_owner", 0, 32'(who0[k]),  32'(k % 2));
                chk("t3_time",  0, 32'(when0[k]), 32'(3 + 4 * k));
            end
        end
        chk("t4_cpu_acks", 1, 32'(c1), 4);
        chk("t4_pnl_acks", 1, 32'(p1), 0);
        for (int g = 0; g < 2; g++) begin cpu_req[g] = 0; pnl_req[g] = 0; end
        repeat (4) @(negedge clk);

        // Reset during STROBE of a write
        pnl_req[0] = 1; pnl_we[0] = 1; pnl_addr[0] = 12'h020; pnl_wdata[0] = 12'h111;
        found = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (wrm[0]) begin found = 1; break; end
        end
        chk("t5_wrm_seen", 0, 32'(found), 1);
        #2 rst = 0; pnl_req[0] = 0;
        #1;
        chk("t5_wrm",  0, 32'(wrm[0]),     0);
        chk("t5_rdm",  0, 32'(rdm[0]),     0);
        chk("t5_busy", 0, 32'(busy[0]),    0);
        chk("t5_pack", 0, 32'(pnl_ack[0]), 0);
        chk("t5_cack", 0, 32'(cpu_ack[0]), 0);
        @(negedge clk);
        rst = 1;
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ack[0] || pnl_ack[0]) n_ack++;
        end
        chk("t5_no_ack", 0, 32'(n_ack), 0);

        // Address change after grant is ignored
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 12'h100;
        @(negedge clk);
        chk("t6_busy", 0, 32'(busy[0]), 1);
        cpu_addr[0] = 12'h200;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("t6_abus", 0, 32'(abus[0]), 32'h100);
        end
        chk("t6_ack", 0, 32'(cpu_ack[0]), 1);
        cpu_req[0] = 0;
        repeat (2) @(negedge clk);

        // Random traffic on both instances, checked by the models
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (cpu_req[g]) begin
                    if (cpu_ack[g]) begin
                        if ($urandom_range(1, 0) == 0) cpu_req[g] = 0;
                        else rand_fields(g, 1'b0);
                    end else if ($urandom_range(7, 0) == 0) rand_fields(g, 1'b0);
                end else if ($urandom_range(2, 0) == 0) begin
                    cpu_req[g] = 1; rand_fields(g, 1'b0);
                end
                if (pnl_req[g]) begin
                    if (pnl_ack[g]) begin
                        if ($urandom_range(1, 0) == 0) pnl_req[g] = 0;
                        else rand_fields(g, 1'b1);
                    end else if ($urandom_range(7, 0) == 0) rand_fields(g, 1'b1);
                end else if ($urandom_range(2, 0) == 0) begin
                    pnl_req[g] = 1; rand_fields(g, 1'b1);
                end
            end
        end
        for (int g = 0; g < 2; g++) begin cpu_req[g] = 0; pnl_req[g] = 0; end
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
